debug_frame_tx: RTL and testbench

- Transmit-side framer between the MIPS_DLX debug snapshot bus and the UART Tx stage.
- On a send request it latches a wide debug snapshot and streams it to Tx one byte at a time, as a framed packet: header, data bytes, XOR checksum.
- It drives Tx's tx_start/tx_dato_in and paces itself on Tx's tx_done_tick, so the command decoder only issues one send per frame.

---
 rtl/debug_frame_tx.sv | 170 +++++++++++++++++
 tb/tb_debug_frame_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: latches a wide debug snapshot on a send request and streams
// it to the UART Tx stage one byte at a time as a framed packet:
//   HEADER, NUM_BYTES data bytes (LSB byte first), XOR checksum of data bytes.
//
// State table:
//   state | meaning
//   IDLE  | waiting for send; busy=0, tx_start=0
//   SEND  | byte(idx) offered on tx_dato_in with tx_start=1 until Tx acks
//   GAP   | tx_start held low GAP_CYCLES cycles before the next byte
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-low reset
//   send        frame request, sampled only in IDLE
//   abort       abandon the current frame (SEND/GAP)
//   snapshot    debug bus, latched on an accepted send
//   tx_done     Tx done tick (level tolerated, rising edge used as ack)
//   tx_start    byte offer strobe to Tx
//   tx_dato_in  byte to Tx, stable while tx_start=1
//   busy        high from accepted send until frame end or abort
//   frame_done  one-cycle pulse after the checksum byte is acked
module debug_frame_tx #(
    parameter int unsigned DATA_W     = 322,
    parameter int unsigned NUM_BYTES  = 41,
    parameter logic [7:0]  HEADER     = 8'hA5,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send,
    input  logic              abort,
    input  logic [DATA_W-1:0] snapshot,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_dato_in,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned SHADOW_W = NUM_BYTES * 8;
    localparam logic [5:0]  LAST_IDX = 6'(NUM_BYTES + 1);
    localparam logic [5:0]  DATA_MAX = 6'(NUM_BYTES);
    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t                state, state_nx;
    logic [SHADOW_W-1:0]   shadow, shadow_nx, snap_pad;
    logic [5:0]            idx, idx_nx, data_idx;
    logic [7:0]            checksum, checksum_nx;
    logic [7:0]            gap_cnt, gap_cnt_nx;
    logic [7:0]            cur_byte, dato_nx;
    logic                  tx_done_q, ack, is_data;
    logic                  start_nx, busy_nx, done_nx;

    assign ack      = tx_done & ~tx_done_q;
    assign data_idx = idx - 6'd1;
    assign is_data  = (idx != 6'd0) && (idx <= DATA_MAX);

    // Padding bits above DATA_W are forced to zero.
    always_comb begin
        snap_pad                = '0;
        snap_pad[DATA_W-1:0]    = snapshot;
    end

    always_comb begin
        if (idx == 6'd0) begin
            cur_byte = HEADER;
        end else if (is_data) begin
            cur_byte = shadow[{data_idx, 3'b000} +: 8];
        end else begin
            cur_byte = checksum;
        end
    end

    always_comb begin
        state_nx    = state;
        shadow_nx   = shadow;
        idx_nx      = idx;
        checksum_nx = checksum;
        gap_cnt_nx  = gap_cnt;
        start_nx    = tx_start;
        dato_nx     = tx_dato_in;
        busy_nx     = busy;
        done_nx     = 1'b0;
        case (state)
            ST_IDLE: begin
                start_nx = 1'b0;
                busy_nx  = 1'b0;
                if (send) begin
                    shadow_nx   = snap_pad;
                    checksum_nx = 8'h00;
                    idx_nx      = 6'd0;
                    busy_nx     = 1'b1;
                    start_nx    = 1'b1;
                    dato_nx     = HEADER;
                    state_nx    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    start_nx = 1'b0;
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else if (ack) begin
                    start_nx = 1'b0;
                    if (is_data) begin
                        checksum_nx = checksum ^ cur_byte;
                    end
                    if (idx == LAST_IDX) begin
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = ST_IDLE;
                    end else begin
                        idx_nx     = idx + 6'd1;
                        gap_cnt_nx = GAP_LOAD;
                        state_nx   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                start_nx = 1'b0;
                if (abort) begin
                    busy_nx  = 1'b0;
                    state_nx = ST_IDLE;
                end else if (gap_cnt == 8'd0) begin
                    // idx already points at the next byte; checksum is final
                    // by the time idx reaches the checksum slot.
                    start_nx = 1'b1;
                    dato_nx  = cur_byte;
                    state_nx = ST_SEND;
                end else begin
                    gap_cnt_nx = gap_cnt - 8'd1;
                end
            end
            default: begin
                start_nx = 1'b0;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            idx        <= 6'd0;
            checksum   <= 8'h00;
            gap_cnt    <= 8'd0;
            tx_done_q  <= 1'b0;
            tx_start   <= 1'b0;
            tx_dato_in <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shadow     <= shadow_nx;
            idx        <= idx_nx;
            checksum   <= checksum_nx;
            gap_cnt    <= gap_cnt_nx;
            tx_done_q  <= tx_done;
            tx_start   <= start_nx;
            tx_dato_in <= dato_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
module tb_debug_frame_tx;

    localparam int DATA_W   = 322;
    localparam int NB       = 41;
    localparam int GAP      = 2;
    localparam int FRAME_TO = 4000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              send  = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] snapshot = '0;
    logic              tx_done = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_dato_in;
    logic              busy;
    logic              frame_done;

    typedef struct {
        logic [7:0] b;
        bit         first;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_count = 0;
    int   ack_delay = 20;
    int   ack_hold = 1;

    debug_frame_tx dut (
        .clock      (clock),
        .reset      (reset),
        .send       (send),
        .abort      (abort),
        .snapshot   (snapshot),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_dato_in (tx_dato_in),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: header, zero-padded data bytes LSB first, XOR of data.
    task automatic push_frame(input logic [DATA_W-1:0] s);
        logic [NB*8-1:0] pad;
        logic [7:0]      chk;
        exp_t            e;
        pad = '0;
        pad[DATA_W-1:0] = s;
        chk = 8'h00;
        e.b = 8'hA5; e.first = 1'b1; sb.push_back(e);
        for (int i = 0; i < NB; i++) begin
            e.b = pad[i*8 +: 8]; e.first = 1'b0;
            chk ^= e.b;
            sb.push_back(e);
        end
        e.b = chk; e.first = 1'b0; sb.push_back(e);
    endtask

    function automatic logic [DATA_W-1:0] rand_snap();
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < 11; i++) s = (s << 32) | DATA_W'($urandom);
        return s;
    endfunction

    // frame_done pulse counter; a pulse must last exactly one cycle.
    initial begin : fd_mon
        bit fd_prev;
        fd_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (frame_done) begin
                fd_count++;
                check("frame_done_width", 64'(fd_prev), 64'd0);
            end
            fd_prev = frame_done;
        end
    end

    // Tx model: pops the scoreboard on each new byte offer and acks after
    // ack_delay cycles with a tx_done level of ack_hold cycles.
    initial begin : tx_model
        bit         pending, prev_start, acked_last, td_was;
        int         wait_cnt, hold_cnt, low_cnt;
        logic [7:0] cur;
        exp_t       e;
        pending = 0; prev_start = 0; acked_last = 0;
        wait_cnt = 0; hold_cnt = 0; low_cnt = 0; cur = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pending = 0; hold_cnt = 0; tx_done = 1'b0;
                prev_start = 0; low_cnt = 0; acked_last = 0;
            end else begin
                td_was = tx_done;
                if (acked_last) check("start_fall_after_ack", 64'(tx_start), 64'd0);
                acked_last = 0;
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) tx_done = 1'b0;
                end
                if (tx_start && !prev_start) begin
                    if (sb.size() == 0) begin
                        check("unexpected_byte", 64'(tx_dato_in), 64'h100);
                    end else begin
                        e = sb.pop_front();
                        check("byte", 64'(tx_dato_in), 64'(e.b));
                        if (!e.first) check("gap_len_ok", 64'(low_cnt >= GAP), 64'd1);
                    end
                    cur = tx_dato_in;
                    pending = 1;
                    wait_cnt = ack_delay;
                end else if (tx_start && prev_start) begin
                    check("dato_stable", 64'(tx_dato_in), 64'(cur));
                end
                if (pending && !tx_start) pending = 0;
                if (pending) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else if (!td_was) begin
                        tx_done = 1'b1;
                        hold_cnt = ack_hold;
                        pending = 0;
                        acked_last = 1;
                    end
                end
                low_cnt = tx_start ? 0 : low_cnt + 1;
                prev_start = tx_start;
            end
        end
    end

    task automatic start_frame(input logic [DATA_W-1:0] s, input bit keep_send);
        @(negedge clock);
        snapshot = s;
        send = 1'b1;
        push_frame(s);
        @(negedge clock);
        if (!keep_send) send = 1'b0;
        check("first_offer_start", 64'(tx_start), 64'd1);
        check("first_offer_busy", 64'(busy), 64'd1);
        check("first_offer_hdr", 64'(tx_dato_in), 64'hA5);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < FRAME_TO);
        check({tag, "_done_in_time"}, 64'(n < FRAME_TO), 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin : main
        int fd0;
        int n;
        logic [DATA_W-1:0] s;

        // reset and idle
        repeat (3) @(negedge clock);
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dato", 64'(tx_dato_in), 64'h00);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        reset = 1'b1;
        repeat (100) @(negedge clock);
        check("idle_tx_start", 64'(tx_start), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_dato", 64'(tx_dato_in), 64'h00);
        check("idle_no_frame_done", 64'(fd_count), 64'd0);

        // frame with two nonzero low bytes
        s = '0;
        s[7:0] = 8'h3C;
        s[15:8] = 8'h5A;
        fd0 = fd_count;
        start_frame(s, 0);
        wait_done("f1");
        @(negedge clock);
        check("f1_busy_after", 64'(busy), 64'd0);
        check("f1_one_pulse", 64'(fd_count - fd0), 64'd1);

        // all ones: last data byte is partially padded
        fd0 = fd_count;
        start_frame('1, 0);
        wait_done("f2");
        @(negedge clock);
        check("f2_busy_after", 64'(busy), 64'd0);
        check("f2_one_pulse", 64'(fd_count - fd0), 64'd1);

        // send held through frame, snapshot changed mid-frame
        s = rand_snap();
        fd0 = fd_count;
        start_frame(s, 1);
        repeat (200) @(negedge clock);
        snapshot = ~s;
        wait_done("f3");
        check("f3_one_pulse", 64'(fd_count - fd0), 64'd1);
        push_frame(snapshot);
        @(negedge clock);
        send = 1'b0;
        check("f4_restart_start", 64'(tx_start), 64'd1);
        check("f4_restart_busy", 64'(busy), 64'd1);
        check("f4_restart_hdr", 64'(tx_dato_in), 64'hA5);

        // abort while byte 10 is offered
        n = 0;
        while (!(sb.size() == NB + 2 - 11 && tx_start) && n < FRAME_TO) begin
            @(negedge clock);
            n++;
        end
        check("abort_reach_byte10", 64'(n < FRAME_TO), 64'd1);
        fd0 = fd_count;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_tx_start", 64'(tx_start), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (60) @(negedge clock);
        check("abort_no_frame_done", 64'(fd_count - fd0), 64'd0);
        check("abort_stays_idle", 64'(tx_start), 64'd0);
        sb.delete();

        // tx_done held high 16 cycles per byte
        ack_hold = 16;
        fd0 = fd_count;
        start_frame(rand_snap(), 0);
        wait_done("f5");
        check("f5_one_pulse", 64'(fd_count - fd0), 64'd1);
        repeat (20) @(negedge clock);
        ack_hold = 1;

        // reset mid-frame clears outputs without a clock edge
        start_frame(rand_snap(), 0);
        repeat (100) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_tx_start", 64'(tx_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_dato", 64'(tx_dato_in), 64'h00);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        fd0 = fd_count;
        start_frame(rand_snap(), 0);
        wait_done("f6");
        @(negedge clock);
        check("f6_busy_after", 64'(busy), 64'd0);
        check("f6_one_pulse", 64'(fd_count - fd0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
